multicycle_ctrl: RTL and testbench

//  Multi-cycle sequencer for the single-ported RV32 subset datapath (LW, SW, ADD/SUB/OR/AND, BEQ/BNE).

---
 rtl/multicycle_ctrl_if.sv | 22 ++
 rtl/multicycle_ctrl.sv | 218 +++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_ctrl_if.sv
// Shared memory port between the multi-cycle sequencer and the single-ported memory.
// Instruction fetch and data access both use this req/ready handshake.
interface multicycle_ctrl_if;
    logic mem_req;
    logic mem_we;
    logic addr_sel;
    logic mem_ready;

    modport master (
        output mem_req,
        output mem_we,
        output addr_sel,
        input  mem_ready
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  addr_sel,
        output mem_ready
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle sequencer for the RV32 subset datapath (LW, SW, ADD/SUB/OR/AND, BEQ/BNE).
// Decodes the instruction register and drives the datapath strobes and the shared memory port.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// S_FETCH  | request instruction at PC; on ready load IR and PC+4
// S_DECODE | classify inst; unsupported encodings go to S_TRAP
// S_EXEC   | ALU operation; branches resolve and retire here
// S_MEM    | data access at ALU address; SW retires on ready
// S_WB     | register file write (ALU result or load data), retire
// S_TRAP   | illegal instruction or memory timeout; left only by rst
module multicycle_ctrl #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [31:0]              inst,
    input  logic                     alu_zero,
    multicycle_ctrl_if.master        mem,
    output logic                     ir_we,
    output logic                     pc_we,
    output logic                     pc_src,
    output logic [1:0]               imm_mode,
    output logic                     alu_src,
    output logic [1:0]               alu_op,
    output logic                     rf_we,
    output logic                     wb_sel,
    output logic                     trap,
    output logic [31:0]              instret
);
    // Immediate-extender modes shared with the sign_ext block.
    localparam logic [1:0] OBJ_I   = 2'b00;
    localparam logic [1:0] OBJ_S   = 2'b01;
    localparam logic [1:0] OBJ_B   = 2'b10;
    localparam logic [1:0] OBJ_R   = 2'b11;
    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_OR  = 2'b10;
    localparam logic [1:0] ALU_AND = 2'b11;
    localparam int CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
    } state_t;

    state_t        state, state_nx;
    logic          retire;
    logic [CW-1:0] wait_cnt;
    logic          mem_wait, timeout, taken;
    logic          req, we, asel;

    logic [6:0] opc, f7;
    logic [2:0] f3;
    logic       is_lw, is_sw, is_rt, is_br, legal;
    logic [1:0] rt_op;
    logic       unused_inst_bits;

    assign opc = inst[6:0];
    assign f3  = inst[14:12];
    assign f7  = inst[31:25];
    // Register and immediate fields are consumed by the datapath, not by the sequencer.
    assign unused_inst_bits = ^{inst[24:15], inst[11:7]};

    assign is_lw = (opc == 7'b0000011);
    assign is_sw = (opc == 7'b0100011);
    assign is_br = (opc == 7'b1100011) && (f3[2:1] == 2'b00);
    assign legal = is_lw | is_sw | is_rt | is_br;
    assign taken = is_br && (f3[0] ? !alu_zero : alu_zero);

    always_comb begin
        is_rt = 1'b0;
        rt_op = ALU_ADD;
        if (opc == 7'b0110011) begin
            case (f3)
                3'b000: begin
                    if (f7 == 7'b0000000) begin
                        is_rt = 1'b1;
                        rt_op = ALU_ADD;
                    end else if (f7 == 7'b0100000) begin
                        is_rt = 1'b1;
                        rt_op = ALU_SUB;
                    end
                end
                3'b110: begin
                    is_rt = (f7 == 7'b0000000);
                    rt_op = ALU_OR;
                end
                3'b111: begin
                    is_rt = (f7 == 7'b0000000);
                    rt_op = ALU_AND;
                end
                default: is_rt = 1'b0;
            endcase
        end
    end

    // A waiting request cycle on the last allowed count traps instead of counting further.
    assign mem_wait = ((state == S_FETCH) || (state == S_MEM)) && !mem.mem_ready;
    generate
        if (MEM_TIMEOUT == 0) begin : g_no_timeout
            assign timeout = 1'b0;
        end else begin : g_timeout
            assign timeout = mem_wait && (wait_cnt == CW'(MEM_TIMEOUT - 1));
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (mem_wait && !timeout) begin
            wait_cnt <= wait_cnt + 1'b1;
        end else begin
            wait_cnt <= '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_FETCH;
            instret <= '0;
        end else begin
            state <= state_nx;
            if (retire) begin
                instret <= instret + 32'd1;
            end
        end
    end

    always_comb begin
        state_nx = state;
        retire   = 1'b0;
        case (state)
            S_FETCH: begin
                if (mem.mem_ready) state_nx = S_DECODE;
                else if (timeout)  state_nx = S_TRAP;
            end
            S_DECODE: state_nx = legal ? S_EXEC : S_TRAP;
            S_EXEC: begin
                if (is_lw || is_sw) begin
                    state_nx = S_MEM;
                end else if (is_rt) begin
                    state_nx = S_WB;
                end else if (is_br) begin
                    state_nx = S_FETCH;
                    retire   = 1'b1;
                end else begin
                    state_nx = S_TRAP;
                end
            end
            S_MEM: begin
                if (mem.mem_ready) begin
                    if (is_lw) begin
                        state_nx = S_WB;
                    end else begin
                        state_nx = S_FETCH;
                        retire   = 1'b1;
                    end
                end else if (timeout) begin
                    state_nx = S_TRAP;
                end
            end
            S_WB: begin
                state_nx = S_FETCH;
                retire   = 1'b1;
            end
            default: state_nx = S_TRAP;
        endcase
    end

    // rst gates every strobe combinationally so an in-flight request drops at once.
    always_comb begin
        req      = 1'b0;
        we       = 1'b0;
        asel     = 1'b0;
        ir_we    = 1'b0;
        pc_we    = 1'b0;
        pc_src   = 1'b0;
        imm_mode = OBJ_I;
        alu_src  = 1'b0;
        alu_op   = ALU_ADD;
        rf_we    = 1'b0;
        wb_sel   = 1'b0;
        trap     = 1'b0;
        if (!rst) begin
            if (state inside {S_DECODE, S_EXEC, S_MEM, S_WB}) begin
                imm_mode = is_lw ? OBJ_I : is_sw ? OBJ_S : is_br ? OBJ_B : is_rt ? OBJ_R : OBJ_I;
                alu_src  = is_lw | is_sw;
                alu_op   = (is_lw | is_sw) ? ALU_ADD : is_br ? ALU_SUB : rt_op;
            end
            case (state)
                S_FETCH: begin
                    req   = 1'b1;
                    ir_we = mem.mem_ready;
                    pc_we = mem.mem_ready;
                end
                S_EXEC: begin
                    pc_we  = taken;
                    pc_src = taken;
                end
                S_MEM: begin
                    req  = 1'b1;
                    asel = 1'b1;
                    we   = is_sw;
                end
                S_WB: begin
                    rf_we  = 1'b1;
                    wb_sel = is_lw;
                end
                S_TRAP:  trap = 1'b1;
                default: trap = 1'b0;
            endcase
        end
    end

    assign mem.mem_req  = req;
    assign mem.mem_we   = we;
    assign mem.addr_sel = asel;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: a memory responder replays a planned instruction stream while a
// monitor compares each retired instruction's observed strobes against a queued expectation.
module tb_multicycle_ctrl;
    localparam logic [1:0] OBJ_I = 2'b00;
    localparam logic [1:0] OBJ_S = 2'b01;
    localparam logic [1:0] OBJ_B = 2'b10;
    localparam logic [1:0] OBJ_R = 2'b11;
    localparam int K_LW = 0, K_SW = 1, K_RT = 2, K_BR = 3, K_ILL = 4;

    typedef struct {
        logic [31:0] idx;
        int          cycles, fetch, data, rf, store, taken;
        logic        wb;
        logic [1:0]  imm, op;
        logic        src;
    } exp_t;

    logic        clk = 1'b0, rst = 1'b1;
    logic [31:0] inst;
    logic        alu_zero;
    logic        ir_we, pc_we, pc_src, alu_src, rf_we, wb_sel, trap;
    logic [1:0]  imm_mode, alu_op;
    logic [31:0] instret;

    logic        auto_mode = 1'b1;
    logic        a_ready = 1'b0, a_zero = 1'b0, m_ready = 1'b0, m_zero = 1'b0;
    logic [31:0] a_inst = '0, m_inst = '0;

    multicycle_ctrl_if mif ();
    assign mif.mem_ready = auto_mode ? a_ready : m_ready;
    assign inst          = auto_mode ? a_inst : m_inst;
    assign alu_zero      = auto_mode ? a_zero : m_zero;

    multicycle_ctrl #(.MEM_TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .inst(inst), .alu_zero(alu_zero), .mem(mif),
        .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src), .imm_mode(imm_mode),
        .alu_src(alu_src), .alu_op(alu_op), .rf_we(rf_we), .wb_sel(wb_sel),
        .trap(trap), .instret(instret)
    );

    always #5 clk = ~clk;

    int n_tests = 0, n_fail = 0, n_issued = 0;
    logic [31:0] instr_q[$];
    logic        zero_q[$];
    int          wait_q[$];
    exp_t        exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [31:0] mk(input int kind, input logic [1:0] sub);
        logic [31:0] r;
        logic [6:0]  f7;
        logic [2:0]  f3;
        r = $urandom;
        case (kind)
            K_LW: return {r[31:15], 3'b010, r[11:7], 7'b0000011};
            K_SW: return {r[31:15], 3'b010, r[11:7], 7'b0100011};
            K_RT: begin
                f7 = (sub == 2'd1) ? 7'b0100000 : 7'b0000000;
                f3 = (sub == 2'd2) ? 3'b110 : (sub == 2'd3) ? 3'b111 : 3'b000;
                return {f7, r[24:15], f3, r[11:7], 7'b0110011};
            end
            default: return {r[31:15], 2'b00, sub[0], r[11:7], 7'b1100011};
        endcase
    endfunction

    // Plan one instruction: memory behaviour for the responder plus the expected effect.
    task automatic issue(input int kind, input logic [1:0] sub, input int fw, input int dw,
                         input logic z, input logic [31:0] ins);
        exp_t e;
        instr_q.push_back(ins);
        zero_q.push_back(z);
        wait_q.push_back(fw);
        if (kind == K_LW || kind == K_SW) wait_q.push_back(dw);
        if (kind != K_ILL) begin
            n_issued++;
            e.idx    = n_issued;
            e.fetch  = fw + 1;
            e.data   = (kind == K_LW || kind == K_SW) ? dw + 1 : 0;
            e.rf     = (kind == K_LW || kind == K_RT) ? 1 : 0;
            e.wb     = (kind == K_LW);
            e.store  = (kind == K_SW) ? 1 : 0;
            e.taken  = (kind == K_BR && (sub[0] ? !z : z)) ? 1 : 0;
            e.imm    = (kind == K_LW) ? OBJ_I : (kind == K_SW) ? OBJ_S : (kind == K_RT) ? OBJ_R : OBJ_B;
            e.op     = (kind == K_RT) ? sub : (kind == K_BR) ? 2'b01 : 2'b00;
            e.src    = (kind == K_LW || kind == K_SW);
            e.cycles = e.fetch + 2 + e.data + e.rf;
            exp_q.push_back(e);
        end
    endtask

    // Memory responder: each access waits its planned number of cycles, then gives ready.
    initial begin
        bit in_acc = 0, load_pend = 0;
        int waits = 0;
        logic [31:0] pend_inst = '0;
        logic pend_zero = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (auto_mode) begin
                if (load_pend) begin
                    a_inst    = pend_inst;
                    a_zero    = pend_zero;
                    load_pend = 0;
                end
                a_ready = 1'b0;
                if (mif.mem_req && !rst) begin
                    if (!in_acc) begin
                        in_acc = 1;
                        waits  = (wait_q.size() > 0) ? wait_q.pop_front() : 1000;
                    end
                    if (waits == 0) begin
                        a_ready = 1'b1;
                        in_acc  = 0;
                        if (!mif.addr_sel && instr_q.size() > 0) begin
                            pend_inst = instr_q.pop_front();
                            pend_zero = zero_q.pop_front();
                            load_pend = 1;
                        end
                    end else begin
                        waits--;
                    end
                end
            end
        end
    end

    // Monitor: accumulate strobes per instruction window, compare when instret advances.
    int   cyc, n_fetch, n_data, n_ir, n_pc4, n_taken, n_rf, n_store, unstable, bad;
    logic wb_seen, have_ctl, src0;
    logic [1:0]  imm0, op0;
    logic [31:0] prev_instret;
    exp_t cur;

    task automatic clear_acc();
        cyc = 0; n_fetch = 0; n_data = 0; n_ir = 0; n_pc4 = 0; n_taken = 0;
        n_rf = 0; n_store = 0; unstable = 0; bad = 0; wb_seen = 1'b0; have_ctl = 1'b0;
        imm0 = '0; op0 = '0; src0 = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rst) begin
            clear_acc();
            prev_instret = '0;
        end else begin
            if (instret !== prev_instret) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_retire", instret, prev_instret);
                end else begin
                    cur = exp_q.pop_front();
                    check("instret", instret, cur.idx);
                    check("cycles", cyc, cur.cycles);
                    check("fetch_cycles", n_fetch, cur.fetch);
                    check("data_cycles", n_data, cur.data);
                    check("ir_we_count", n_ir, 1);
                    check("pc_plus4_count", n_pc4, 1);
                    check("branch_taken", n_taken, cur.taken);
                    check("rf_we_count", n_rf, cur.rf);
                    if (cur.rf != 0) check("wb_sel", wb_seen, cur.wb);
                    check("store_count", n_store, cur.store);
                    check("imm_mode", imm0, cur.imm);
                    check("alu_op", op0, cur.op);
                    check("alu_src", src0, cur.src);
                    check("ctrl_stable", unstable, 0);
                    check("mem_we_misuse", bad, 0);
                end
                clear_acc();
                prev_instret = instret;
            end
            cyc++;
            if (ir_we) n_ir++;
            if (pc_we && !pc_src) n_pc4++;
            if (pc_we && pc_src) n_taken++;
            if (rf_we) begin
                n_rf++;
                wb_seen = wb_sel;
            end
            if (mif.mem_req && mif.addr_sel) n_data++;
            if (mif.mem_req && mif.addr_sel && mif.mem_we && mif.mem_ready) n_store++;
            if (mif.mem_we && !(mif.mem_req && mif.addr_sel)) bad++;
            if (mif.mem_req && !mif.addr_sel) begin
                n_fetch++;
            end else if (!have_ctl) begin
                have_ctl = 1'b1;
                imm0 = imm_mode; op0 = alu_op; src0 = alu_src;
            end else if (imm_mode !== imm0 || alu_op !== op0 || alu_src !== src0) begin
                unstable++;
            end
        end
    end

    function automatic logic [12:0] strobes();
        return {mif.mem_req, mif.mem_we, mif.addr_sel, ir_we, pc_we, pc_src, imm_mode,
                alu_src, alu_op, rf_we, wb_sel};
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        m_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        int n, quiet_bad;
        logic [1:0] sub;
        int kind;

        // Plan: directed opening instructions, a random legal stream, then an illegal opcode.
        issue(K_RT, 2'd0, 0, 0, 1'b0, 32'h002081B3);
        issue(K_LW, 2'd0, 0, 3, 1'b0, 32'h0000A183);
        issue(K_BR, 2'd0, 0, 0, 1'b1, 32'h00208463);
        issue(K_BR, 2'd0, 1, 0, 1'b0, 32'h00208463);
        issue(K_BR, 2'd1, 0, 0, 1'b0, 32'h00209463);
        for (int i = 0; i < 40; i++) begin
            kind = $urandom_range(0, 3);
            sub  = (kind == K_RT) ? 2'($urandom_range(0, 3)) :
                   (kind == K_BR) ? 2'($urandom_range(0, 1)) : 2'd0;
            issue(kind, sub, $urandom_range(0, 4), $urandom_range(0, 4),
                  1'($urandom_range(0, 1)), mk(kind, sub));
        end
        issue(K_ILL, 2'd0, $urandom_range(0, 2), 0, 1'b0, 32'h0000007F);

        repeat (2) @(posedge clk);
        #1;
        check("reset_strobes", {19'd0, strobes()}, 32'd0);
        check("reset_trap", {31'd0, trap}, 32'd0);
        check("reset_instret", instret, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        #1 check("first_cycle_fetch", {29'd0, mif.mem_req, mif.addr_sel, mif.mem_we}, 32'b100);

        n = 0;
        while (!(exp_q.size() == 0 && trap === 1'b1) && n < 5000) begin
            @(posedge clk);
            n++;
        end
        check("stream_drained", exp_q.size(), 0);
        check("illegal_opcode_trap", {31'd0, trap}, 32'd1);

        quiet_bad = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (strobes() !== 13'd0 || trap !== 1'b1 || instret !== n_issued) quiet_bad++;
        end
        check("trap_quiet_100", quiet_bad, 0);
        check("trap_instret_frozen", instret, n_issued);

        // Manual memory control from here on.
        auto_mode = 1'b0;
        do_reset();
        m_ready = 1'b1;
        @(posedge clk);
        #1 m_ready = 1'b0;
        m_inst = 32'h4020E1B3;
        #1 check("or_f7_decode_no_trap", {31'd0, trap}, 32'd0);
        @(posedge clk);
        #1 check("or_f7_trap", {31'd0, trap}, 32'd1);
        check("or_f7_strobes", {19'd0, strobes()}, 32'd0);

        // SW interrupted by reset while waiting in its data access.
        do_reset();
        m_ready = 1'b1;
        @(posedge clk);
        #1 m_ready = 1'b0;
        m_inst = 32'h0020A023;
        @(posedge clk);
        @(posedge clk);
        #1 check("sw_mem_phase", {29'd0, mif.mem_req, mif.mem_we, mif.addr_sel}, 32'b111);
        @(posedge clk);
        #3 rst = 1'b1;
        #1 check("rst_drops_req", {30'd0, mif.mem_req, mif.mem_we}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        #1 check("after_rst_fetch", {29'd0, mif.mem_req, mif.addr_sel, mif.mem_we}, 32'b100);
        check("after_rst_instret", instret, 32'd0);

        // Fetch never answered: trap after exactly 16 request cycles.
        n = 0;
        while (trap !== 1'b1 && n < 40) begin
            if (mif.mem_req) n++;
            @(posedge clk);
            #1;
        end
        check("timeout_req_cycles", n, 16);
        check("timeout_trap", {31'd0, trap}, 32'd1);

        // Ready on the 16th request cycle completes normally.
        do_reset();
        #1;
        for (int k = 1; k <= 16; k++) begin
            if (k == 16) begin
                m_ready = 1'b1;
                #1 check("ready_at_limit_ir_we", {31'd0, ir_we}, 32'd1);
            end
            @(posedge clk);
            #1;
        end
        m_ready = 1'b0;
        check("limit_no_trap", {31'd0, trap}, 32'd0);
        check("limit_in_decode", {31'd0, mif.mem_req}, 32'd0);
        @(posedge clk);
        #1 check("limit_no_trap_later", {31'd0, trap}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
